// File: rtl/ql_screen_writer_pkg.sv
// Shared definitions for the QL screen writer.
//   - Mode encodings, frame geometry and pixels-per-word counts.
//   - vid_word_t: one queued video RAM write {eof, addr, data}.
//   - pack_bits(): bit contribution of a single pixel to a packed screen word.
//   - last_idx(): index of the final pixel of a word for a given mode.
package ql_screen_writer_pkg;

  localparam logic        QlMode4       = 1'b0;
  localparam logic        QlMode8       = 1'b1;
  localparam int unsigned QlLines       = 256;
  localparam int unsigned QlWordsLine   = 64;
  localparam int unsigned QlAddrW       = 14;
  localparam int unsigned QlPxWordMode4 = 8;
  localparam int unsigned QlPxWordMode8 = 4;

  typedef struct packed {
    logic               eof;
    logic [QlAddrW-1:0] addr;
    logic [15:0]        data;
  } vid_word_t;

  // Place pixel 0 at the top of each byte, then shift right by its slot.
  // Mode-4 slots are 1 bit wide per byte, mode-8 slots are 2 bits wide.
  function automatic logic [15:0] pack_bits(input logic       mode,
                                            input logic [2:0] idx,
                                            input logic [2:0] rgb,
                                            input logic       flash);
    logic [15:0] seed;
    logic [2:0]  shamt;
    if (mode == QlMode8) begin
      seed  = {rgb[2], flash, 6'b0, rgb[1], rgb[0], 6'b0};
      shamt = {idx[1:0], 1'b0};
    end else begin
      seed  = {rgb[2], 7'b0, rgb[1], 7'b0};
      shamt = idx;
    end
    return seed >> shamt;
  endfunction

  function automatic logic [2:0] last_idx(input logic mode);
    return (mode == QlMode8) ? 3'(QlPxWordMode8 - 1) : 3'(QlPxWordMode4 - 1);
  endfunction

endpackage

// File: rtl/ql_word_fifo.sv
// Two-entry FIFO of completed screen words waiting for video RAM.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (clears entries and pointers)
//   push, din         enqueue din; ignored while full
//   pop               dequeue head; ignored while empty
//   full, empty       occupancy flags
//   head              oldest entry (all-zero out of reset)
module ql_word_fifo
  import ql_screen_writer_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  vid_word_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output vid_word_t head
);

  vid_word_t  mem_q [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  always_comb begin
    full    = (count_q == 2'd2);
    empty   = (count_q == 2'd0);
    head    = mem_q[rd_q];
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wr_d    = do_push ? ~wr_q : wr_q;
    rd_d    = do_pop ? ~rd_q : rd_q;
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
      end
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ql_screen_writer.sv
// Write side of the QL screen memory. Packs a raster-order RGB pixel stream into
// 16-bit mode-4 (8 px/word) or mode-8 (4 px/word) words and writes them to video RAM.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mode                         0 = mode-4, 1 = mode-8; latched on an accepted sof pixel
//   pix_valid/pix_ready          pixel handshake
//   pix_sof                      first pixel of a frame
//   pix_rgb, pix_flash           {g,r,b} colour, mode-8 flash bit
//   vid_we/vid_wack              write request, held until acknowledged
//   vid_waddr, vid_wdata         word address {y, xw} and packed word
//   frame_done                   one-cycle pulse after the last word of a frame is acked
module ql_screen_writer
  import ql_screen_writer_pkg::*;
#(
  parameter int unsigned Lines     = QlLines,
  parameter int unsigned WordsLine = QlWordsLine
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               mode,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               pix_sof,
  input  logic [2:0]         pix_rgb,
  input  logic               pix_flash,
  output logic               vid_we,
  output logic [QlAddrW-1:0] vid_waddr,
  output logic [15:0]        vid_wdata,
  input  logic               vid_wack,
  output logic               frame_done
);

  localparam logic [5:0] XwLast = 6'(WordsLine - 1);
  localparam logic [7:0] YLast  = 8'(Lines - 1);

  logic        mode_q, mode_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] pack_q, pack_d;
  logic [5:0]  xw_q, xw_d;
  logic [7:0]  y_q, y_d;
  logic        done_q, done_d;

  logic        accept, sof_acc;
  logic        mode_eff;
  logic [2:0]  idx_eff;
  logic [5:0]  xw_eff;
  logic [7:0]  y_eff;
  logic [15:0] pack_new;
  logic        word_last, line_end, frame_end;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  vid_word_t   fifo_din, fifo_head;

  ql_word_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Stall only the pixel that would complete a word while no FIFO slot is free.
  assign pix_ready = reset_n & ~(fifo_full & (idx_q == last_idx(mode_q)));

  assign vid_we     = ~fifo_empty;
  assign vid_waddr  = fifo_head.addr;
  assign vid_wdata  = fifo_head.data;
  assign fifo_pop   = vid_we & vid_wack;
  assign frame_done = done_q;

  // An accepted sof restarts the frame in the same cycle: the pixel it carries is
  // pixel 0 at address 0 and is packed with the newly sampled mode.
  always_comb begin
    accept    = pix_valid & pix_ready;
    sof_acc   = accept & pix_sof;
    mode_eff  = sof_acc ? mode : mode_q;
    idx_eff   = sof_acc ? 3'd0 : idx_q;
    xw_eff    = sof_acc ? 6'd0 : xw_q;
    y_eff     = sof_acc ? 8'd0 : y_q;
    // Bits left over from an earlier word never leak into a new one.
    pack_new  = ((idx_eff == 3'd0) ? 16'h0000 : pack_q)
                | pack_bits(mode_eff, idx_eff, pix_rgb, pix_flash);
    word_last = (idx_eff == last_idx(mode_eff));
    line_end  = (xw_eff == XwLast);
    frame_end = line_end & (y_eff == YLast);

    fifo_push     = accept & word_last;
    fifo_din.eof  = frame_end;
    fifo_din.addr = {y_eff, xw_eff};
    fifo_din.data = pack_new;
  end

  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    pack_d = pack_q;
    xw_d   = xw_q;
    y_d    = y_q;
    done_d = fifo_pop & fifo_head.eof;
    if (accept) begin
      mode_d = mode_eff;
      if (word_last) begin
        idx_d  = 3'd0;
        pack_d = 16'h0000;
        xw_d   = line_end ? 6'd0 : xw_eff + 6'd1;
        if (line_end) begin
          y_d = frame_end ? 8'd0 : y_eff + 8'd1;
        end else begin
          y_d = y_eff;
        end
      end else begin
        idx_d  = idx_eff + 3'd1;
        pack_d = pack_new;
        xw_d   = xw_eff;
        y_d    = y_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= QlMode4;
      idx_q  <= 3'd0;
      pack_q <= 16'h0000;
      xw_q   <= 6'd0;
      y_q    <= 8'd0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      pack_q <= pack_d;
      xw_q   <= xw_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_ql_screen_writer.sv
module tb_ql_screen_writer;

  localparam int unsigned TbLines    = 8;
  localparam int unsigned TbWords    = 64;
  localparam int unsigned FrameWords = TbLines * TbWords;

  logic        clk;
  logic        reset_n;
  logic        mode;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic [2:0]  pix_rgb;
  logic        pix_flash;
  logic        vid_we;
  logic [13:0] vid_waddr;
  logic [15:0] vid_wdata;
  logic        vid_wack;
  logic        frame_done;

  ql_screen_writer #(
    .Lines     (TbLines),
    .WordsLine (TbWords)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode       (mode),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_rgb    (pix_rgb),
    .pix_flash  (pix_flash),
    .vid_we     (vid_we),
    .vid_waddr  (vid_waddr),
    .vid_wdata  (vid_wdata),
    .vid_wack   (vid_wack),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        eof;
    logic [13:0] addr;
    logic [15:0] data;
  } exp_t;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  logic [3:0]  mdl_px[$];
  bit          mdl_mode = 1'b0;
  int          mdl_word = 0;
  int          writes_seen = 0;
  int          done_pulses = 0;
  logic [13:0] last_addr = '0;
  int          wack_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: collect pixels of the current word, build the word from the
  // bit-placement rules, and number words linearly through the frame.
  task automatic model_accept(input logic sof, input logic [2:0] rgb, input logic fl,
                              input logic md);
    logic [15:0] w;
    logic        g, r, b, f;
    int          n;
    if (sof) begin
      mdl_px.delete();
      mdl_mode = md;
      mdl_word = 0;
    end
    mdl_px.push_back({rgb, fl});
    n = mdl_mode ? 4 : 8;
    if (mdl_px.size() == n) begin
      w = 16'h0000;
      for (int k = 0; k < n; k++) begin
        g = mdl_px[k][3];
        r = mdl_px[k][2];
        b = mdl_px[k][1];
        f = mdl_px[k][0];
        if (!mdl_mode) begin
          w[15-k] = g;
          w[7-k]  = r;
        end else begin
          w[15-2*k] = g;
          w[14-2*k] = f;
          w[7-2*k]  = r;
          w[6-2*k]  = b;
        end
      end
      exp_q.push_back('{eof: (mdl_word == FrameWords - 1), addr: 14'(mdl_word), data: w});
      mdl_word = (mdl_word + 1) % FrameWords;
      mdl_px.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_px.delete();
    mdl_mode = 1'b0;
    mdl_word = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
  task automatic send_pixel(input logic sof, input logic [2:0] rgb, input logic fl,
                            input logic md);
    bit done = 1'b0;
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_rgb   = rgb;
    pix_flash = fl;
    mode      = md;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (pix_ready) begin
        @(posedge clk);
        model_accept(sof, rgb, fl, md);
        done = 1'b1;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL pixel_accept: got no pix_ready within 2000 cycles, want accept");
      @(posedge clk);
    end
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic offer_once(input logic sof, input logic [2:0] rgb, input logic md,
                            output bit acc);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_rgb   = rgb;
    pix_flash = 1'b0;
    mode      = md;
    @(negedge clk);
    acc = pix_ready;
    @(posedge clk);
    if (acc) model_accept(sof, rgb, 1'b0, md);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !vid_we) done = 1'b1;
    end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (wack_mode)
      0:       vid_wack = 1'b0;
      1:       vid_wack = 1'b1;
      default: vid_wack = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshakes observed at the negedge complete at the next posedge.
  exp_t        mon_e;
  bit          done_pending = 1'b0;
  bit          hold_valid = 1'b0;
  logic [13:0] hold_addr;
  logic [15:0] hold_data;

  always @(negedge clk) begin
    if (!reset_n) begin
      done_pending = 1'b0;
      hold_valid   = 1'b0;
    end else begin
      check("frame_done", frame_done, done_pending);
      if (frame_done) done_pulses++;
      if (hold_valid) begin
        check("hold_we", vid_we, 1);
        check("hold_addr", vid_waddr, hold_addr);
        check("hold_data", vid_wdata, hold_data);
      end
      hold_valid   = vid_we && !vid_wack;
      hold_addr    = vid_waddr;
      hold_data    = vid_wdata;
      done_pending = 1'b0;
      if (vid_we && vid_wack) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                   vid_waddr, vid_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr", vid_waddr, mon_e.addr);
          check("write_data", vid_wdata, mon_e.data);
          done_pending = mon_e.eof;
        end
        writes_seen++;
        last_addr = vid_waddr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w0, d0, nacc;
    bit          acc;
    logic [2:0]  t2_px[8];
    logic [2:0]  t3_px[4];
    logic        md, sof;

    reset_n   = 1'b0;
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    pix_rgb   = 3'b111;
    pix_flash = 1'b0;
    mode      = 1'b0;
    vid_wack  = 1'b0;

    // 1. reset state
    #23;
    check("rst_we", vid_we, 0);
    check("rst_waddr", vid_waddr, 0);
    check("rst_wdata", vid_wdata, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ready", pix_ready, 0);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    reset_n   = 1'b1;
    #1;
    check("ready_after_rst", pix_ready, 1);
    @(posedge clk);
    #1;

    // 2. mode-4 single word
    wack_mode = 1;
    t2_px = '{3'b100, 3'b010, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    for (int i = 0; i < 8; i++) send_pixel(i == 0, t2_px[i], 1'b0, 1'b0);
    check("t2_we_latency", vid_we, 1);
    check("t2_addr", vid_waddr, 14'h0000);
    check("t2_data", vid_wdata, 16'hA060);
    wait_drain("t2_drain");

    // 3. mode-8 single word
    t3_px = '{3'b101, 3'b010, 3'b001, 3'b111};
    for (int i = 0; i < 4; i++) send_pixel(i == 0, t3_px[i], 1'b0, 1'b1);
    check("t3_we_latency", vid_we, 1);
    check("t3_addr", vid_waddr, 14'h0000);
    check("t3_data", vid_wdata, 16'h8267);
    wait_drain("t3_drain");

    // 4. backpressure with the RAM stalled
    wack_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    nacc = 0;
    for (int i = 0; i < 23; i++) begin
      offer_once(i == 0, 3'($urandom), 1'b0, acc);
      if (acc) nacc++;
    end
    check("t4_accepted", nacc, 23);
    offer_once(1'b0, 3'b110, 1'b0, acc);
    check("t4_ready_24th", acc, 0);
    wack_mode = 1;
    send_pixel(1'b0, 3'b110, 1'b0, 1'b0);
    wait_drain("t4_drain");
    check("t4_last_addr", last_addr, 14'h0002);

    // 5. full frame
    w0 = writes_seen;
    d0 = done_pulses;
    for (int i = 0; i < FrameWords * 8; i++) send_pixel(i == 0, 3'($urandom), 1'b0, 1'b0);
    wait_drain("t5_drain");
    check("t5_writes", writes_seen - w0, FrameWords);
    check("t5_last_addr", last_addr, FrameWords - 1);
    check("t5_done_pulses", done_pulses - d0, 1);
    for (int i = 0; i < 8; i++) send_pixel(1'b0, 3'($urandom), 1'b0, 1'b1);
    wait_drain("t5_wrap_drain");
    check("t5_wrap_addr", last_addr, 14'h0000);

    // 6. partial word discarded by sof; mode held through the frame
    for (int i = 0; i < 3; i++) send_pixel(1'b0, 3'b111, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_pixel(i == 0, 3'($urandom), 1'b0, 1'b0);
    wait_drain("t6_drain");
    check("t6_addr", last_addr, 14'h0000);
    for (int i = 0; i < 8; i++) send_pixel(i == 0, 3'($urandom), 1'($urandom), i == 0);
    wait_drain("t6_mode_drain");
    check("t6_mode_addr", last_addr, 14'h0001);

    // 7. reset while writes are pending
    wack_mode = 0;
    for (int i = 0; i < 16; i++) send_pixel(i == 0, 3'($urandom), 1'b0, 1'b0);
    check("t7_we_pending", vid_we, 1);
    reset_n = 1'b0;
    #1;
    check("t7_we_dropped", vid_we, 0);
    check("t7_wdata_clear", vid_wdata, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    wack_mode = 1;
    for (int i = 0; i < 8; i++) send_pixel(1'b0, 3'($urandom), 1'b1, 1'b1);
    wait_drain("t7_drain");
    check("t7_addr", last_addr, 14'h0000);

    // 8. randomized traffic
    wack_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      sof = (i == 0) || ($urandom_range(0, 399) == 0);
      md  = 1'($urandom);
      send_pixel(sof, 3'($urandom), 1'($urandom), md);
    end
    wack_mode = 1;
    wait_drain("t8_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
